// File: rtl/cachelinebus.sv
// ---------------------------------------------------------------------------
// cachelinebus
//
// Burst bus engine between the I$/D$ cache and an AHB-Lite bus. One cache-line
// request becomes one incrementing AHB burst of BEATSPERLINE beats: either a
// line fetch assembled into FetchBuffer, or a dirty-line writeback whose data
// is pulled from the cache one word per beat, indexed by BeatCount.
//
// Ports
//   HCLK, HRESETn        clock (rising edge), asynchronous active-low reset
//   CacheBusRW[1:0]      bit1 = line fetch, bit0 = writeback (held until ack)
//   CacheBusAdr          line-aligned physical address (held until ack)
//   Flush                cancels a request that has not been accepted yet
//   CacheReadDataWord    cache word selected by BeatCount (writeback source)
//   CacheBusAck          one-cycle pulse when the last data phase completes
//   BusCommitted         burst in flight, must not be interrupted
//   SelBusBeat           cache word mux must follow BeatCount
//   BeatCount            beat index of the address phase on the bus
//   FetchBuffer          assembled fetched line
//   HADDR/HTRANS/HBURST/HSIZE/HWRITE/HWDATA   AHB-Lite master outputs
//   HREADY/HRDATA        AHB-Lite master inputs
// ---------------------------------------------------------------------------
module cachelinebus #(
    parameter int PA_BITS = 32,
    parameter int AHBW    = 64,
    parameter int LINELEN = 512,
    parameter int LOGBWPL = $clog2(LINELEN / AHBW)
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [1:0]           CacheBusRW,
    input  logic [PA_BITS-1:0]   CacheBusAdr,
    input  logic                 Flush,
    input  logic [AHBW-1:0]      CacheReadDataWord,
    output logic                 CacheBusAck,
    output logic                 BusCommitted,
    output logic                 SelBusBeat,
    output logic [LOGBWPL-1:0]   BeatCount,
    output logic [LINELEN-1:0]   FetchBuffer,
    output logic [PA_BITS-1:0]   HADDR,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HBURST,
    output logic [2:0]           HSIZE,
    output logic                 HWRITE,
    output logic [AHBW-1:0]      HWDATA,
    input  logic                 HREADY,
    input  logic [AHBW-1:0]      HRDATA
);

    localparam int BEATSPERLINE = LINELEN / AHBW;
    localparam int BYTE_OFF     = $clog2(AHBW / 8);
    localparam int LINE_OFF     = $clog2(LINELEN / 8);

    localparam logic [LOGBWPL-1:0] LAST_BEAT = LOGBWPL'(BEATSPERLINE - 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // Fixed-length INCR burst code when the line length matches one,
    // otherwise an undefined-length INCR burst.
    function automatic logic [2:0] burst_code(input int beats);
        logic [2:0] code;
        case (beats)
            4:       code = 3'b011;
            8:       code = 3'b101;
            16:      code = 3'b111;
            default: code = 3'b001;
        endcase
        return code;
    endfunction

    localparam logic [2:0] HBURST_C = burst_code(BEATSPERLINE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_LAST  = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [LOGBWPL-1:0]   beat_q, beat_d;     // address-phase beat index
    logic [LOGBWPL-1:0]   idx_q, idx_d;       // data-phase beat index
    logic [AHBW-1:0]      hwdata_q, hwdata_d;
    logic [LINELEN-1:0]   fetch_q, fetch_d;

    logic                 req_s;
    logic                 addr_acc_s;         // address phase accepted this cycle
    logic                 data_done_s;        // a data phase completes this cycle
    logic                 ack_s;
    logic [1:0]           htrans_s;

    assign req_s = (|CacheBusRW) & ~Flush;

    // Next-state logic of the burst sequencer and its bus handshake strobes.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        htrans_s    = TRANS_IDLE;
        addr_acc_s  = 1'b0;
        data_done_s = 1'b0;
        ack_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    htrans_s = TRANS_NONSEQ;
                    if (HREADY) begin
                        addr_acc_s = 1'b1;
                        state_d    = ST_BURST;
                        beat_d     = LOGBWPL'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Flush or no request: nothing on the bus.
                    htrans_s = TRANS_IDLE;
                end
            end
            ST_BURST: begin
                htrans_s = TRANS_SEQ;
                if (HREADY) begin
                    addr_acc_s  = 1'b1;
                    data_done_s = 1'b1;
                    // LAST is entered on the all-ones beat, so beat_q never wraps.
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_LAST;
                    end else begin
                        beat_d = beat_q + LOGBWPL'(1);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_LAST: begin
                htrans_s = TRANS_IDLE;
                if (HREADY) begin
                    data_done_s = 1'b1;
                    ack_s       = 1'b1;
                    state_d     = ST_IDLE;
                    beat_d      = '0;
                end else begin
                    state_d = ST_LAST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Data-path next values: data-phase index, write data and fetch buffer.
    always_comb begin
        idx_d    = idx_q;
        hwdata_d = hwdata_q;
        fetch_d  = fetch_q;
        if (data_done_s && CacheBusRW[1]) begin
            fetch_d[int'(idx_q) * AHBW +: AHBW] = HRDATA;
        end else begin
            fetch_d = fetch_q;
        end
        // Index and write data follow the address phase into its data phase.
        if (addr_acc_s) begin
            idx_d    = beat_q;
            hwdata_d = CacheReadDataWord;
        end else begin
            idx_d    = idx_q;
            hwdata_d = hwdata_q;
        end
    end

    // State, counters and data registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            idx_q    <= '0;
            hwdata_q <= '0;
            fetch_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            idx_q    <= idx_d;
            hwdata_q <= hwdata_d;
            fetch_q  <= fetch_d;
        end
    end

    // Address of the beat being presented; in IDLE it is the line base itself.
    always_comb begin
        if (state_q == ST_IDLE) begin
            HADDR = CacheBusAdr;
        end else begin
            HADDR = {CacheBusAdr[PA_BITS-1:LINE_OFF], beat_q, {BYTE_OFF{1'b0}}};
        end
    end

    // HTRANS is forced IDLE during reset even if the cache still holds a request.
    assign HTRANS       = HRESETn ? htrans_s : TRANS_IDLE;
    assign HBURST       = HBURST_C;
    assign HSIZE        = 3'(BYTE_OFF);
    assign HWRITE       = CacheBusRW[0];
    assign HWDATA       = hwdata_q;
    assign CacheBusAck  = ack_s;
    assign BusCommitted = (state_q != ST_IDLE);
    assign SelBusBeat   = (state_q != ST_IDLE) | (|CacheBusRW);
    assign BeatCount    = beat_q;
    assign FetchBuffer  = fetch_q;

endmodule

// File: tb/tb_cachelinebus.sv
module tb_cachelinebus;

    localparam int N = 8;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [1:0]   CacheBusRW;
    logic [31:0]  CacheBusAdr;
    logic         Flush;
    logic [63:0]  CacheReadDataWord;
    logic         CacheBusAck;
    logic         BusCommitted;
    logic         SelBusBeat;
    logic [2:0]   BeatCount;
    logic [511:0] FetchBuffer;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic [2:0]   HSIZE;
    logic         HWRITE;
    logic [63:0]  HWDATA;
    logic         HREADY;
    logic [63:0]  HRDATA;

    int checks   = 0;
    int failures = 0;

    cachelinebus dut (
        .HCLK              (HCLK),
        .HRESETn           (HRESETn),
        .CacheBusRW        (CacheBusRW),
        .CacheBusAdr       (CacheBusAdr),
        .Flush             (Flush),
        .CacheReadDataWord (CacheReadDataWord),
        .CacheBusAck       (CacheBusAck),
        .BusCommitted      (BusCommitted),
        .SelBusBeat        (SelBusBeat),
        .BeatCount         (BeatCount),
        .FetchBuffer       (FetchBuffer),
        .HADDR             (HADDR),
        .HTRANS            (HTRANS),
        .HBURST            (HBURST),
        .HSIZE             (HSIZE),
        .HWRITE            (HWRITE),
        .HWDATA            (HWDATA),
        .HREADY            (HREADY),
        .HRDATA            (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // Cache model: the word at index BeatCount is 0xA0 + BeatCount.
    assign CacheReadDataWord = 64'h00000000000000A0 + 64'(BeatCount);

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One burst; stall0/stall5 = HREADY-low cycles while beat 0 / beat 5 address is presented.
    task automatic do_burst(input logic [1:0] rw, input logic [31:0] adr,
                            input int stall0, input int stall5, input int exp_ack);
        int eb   = 0;    // beat whose address phase is expected (N = final data phase)
        int dp   = -1;   // beat whose data phase is in progress
        int s0   = 0;
        int s5   = 0;
        int cyc  = 0;
        int ackc = -1;
        bit done = 1'b0;
        logic hr;
        logic [511:0] line;
        while (!done && cyc < 40) begin
            #1;
            CacheBusRW  = rw;
            CacheBusAdr = adr;
            Flush       = 1'b0;
            hr          = 1'b1;
            if (eb == 0 && s0 < stall0) begin hr = 1'b0; s0++; end
            if (eb == 5 && s5 < stall5) begin hr = 1'b0; s5++; end
            HREADY = hr;
            HRDATA = (dp >= 0) ? 64'(dp) : 64'h0;
            #4;
            if (eb < N) begin
                check("haddr", 512'(HADDR), 512'(adr + 32'(eb * 8)));
                check("htrans", 512'(HTRANS), (eb == 0) ? 512'h2 : 512'h3);
                check("beatcount", 512'(BeatCount), 512'(eb));
            end else begin
                check("htrans_last", 512'(HTRANS), 512'h0);
            end
            check("ack", 512'(CacheBusAck), 512'(eb == N && hr));
            check("committed", 512'(BusCommitted), 512'(eb != 0));
            check("selbusbeat", 512'(SelBusBeat), 512'h1);
            check("hburst", 512'(HBURST), 512'h5);
            check("hsize", 512'(HSIZE), 512'h3);
            check("hwrite", 512'(HWRITE), 512'(rw[0]));
            if (rw[0] && dp >= 0) check("hwdata", 512'(HWDATA), 512'(64'hA0 + 64'(dp)));
            @(posedge HCLK);
            if (hr) begin
                if (eb == N) begin
                    done = 1'b1;
                    ackc = cyc;
                end else begin
                    dp = eb;
                    eb++;
                end
            end
            cyc++;
        end
        check("burst_done", 512'(done), 512'h1);
        check("ack_cycle", 512'(ackc), 512'(exp_ack));
        if (rw[1]) begin
            line = '0;
            for (int i = 0; i < N; i++) line[i*64 +: 64] = 64'(i);
            #1;
            check("fetchbuf", FetchBuffer, line);
        end
    endtask

    task automatic idle_cycle();
        #1;
        CacheBusRW = 2'b00;
        Flush      = 1'b0;
        HREADY     = 1'b1;
        @(posedge HCLK);
    endtask

    initial begin
        HRESETn    = 1'b0;
        CacheBusRW = 2'b00;
        CacheBusAdr = 32'h0;
        Flush      = 1'b0;
        HREADY     = 1'b1;
        HRDATA     = 64'h0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_htrans", 512'(HTRANS), 512'h0);
        check("rst_ack", 512'(CacheBusAck), 512'h0);
        check("rst_committed", 512'(BusCommitted), 512'h0);
        check("rst_fetchbuf", FetchBuffer, 512'h0);
        check("rst_hwdata", 512'(HWDATA), 512'h0);
        check("rst_beatcount", 512'(BeatCount), 512'h0);
        check("rst_selbusbeat", 512'(SelBusBeat), 512'h0);
        HRESETn = 1'b1;
        @(posedge HCLK);

        // Zero-wait fetch, then the same fetch with wait states.
        do_burst(2'b10, 32'h8000_0040, 0, 0, 8);
        idle_cycle();
        do_burst(2'b10, 32'h8000_0040, 2, 2, 12);
        idle_cycle();

        // Writeback immediately followed by a fetch.
        do_burst(2'b01, 32'h8000_1000, 0, 0, 8);
        do_burst(2'b10, 32'h8000_2000, 0, 0, 8);
        idle_cycle();

        // Flush while a request is pending in IDLE.
        for (int k = 0; k < 2; k++) begin
            #1;
            CacheBusRW  = 2'b10;
            CacheBusAdr = 32'h8000_3000;
            Flush       = 1'b1;
            HREADY      = 1'b1;
            #4;
            check("flush_htrans", 512'(HTRANS), 512'h0);
            check("flush_ack", 512'(CacheBusAck), 512'h0);
            check("flush_committed", 512'(BusCommitted), 512'h0);
            @(posedge HCLK);
        end
        do_burst(2'b10, 32'h8000_3000, 0, 0, 8);
        idle_cycle();

        // Reset at beat 3 of a fetch.
        #1;
        CacheBusRW  = 2'b10;
        CacheBusAdr = 32'h8000_4000;
        Flush       = 1'b0;
        HREADY      = 1'b1;
        HRDATA      = 64'h5555;
        repeat (3) @(posedge HCLK);
        #1;
        check("mid_beatcount", 512'(BeatCount), 512'h3);
        check("mid_committed", 512'(BusCommitted), 512'h1);
        check("mid_fb_nonzero", 512'(|FetchBuffer), 512'h1);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_htrans", 512'(HTRANS), 512'h0);
        check("mid_rst_committed", 512'(BusCommitted), 512'h0);
        check("mid_rst_fetchbuf", FetchBuffer, 512'h0);
        check("mid_rst_ack", 512'(CacheBusAck), 512'h0);
        CacheBusRW = 2'b00;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        do_burst(2'b10, 32'h8000_4000, 0, 0, 8);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cachelinebus.md
# cachelinebus

Burst bus engine directly downstream of the I$/D$ cache. Turns one cache-line request on `CacheBusRW`/`CacheBusAdr` into one AHB-Lite burst of `LINELEN/AHBW` beats: a line fetch into `FetchBuffer`, or a dirty-line writeback sourced beat-by-beat from the cache through `BeatCount`. It returns a single-cycle `CacheBusAck` when the last data phase completes.

## Interface
Parameters:
- `PA_BITS`, default 32: physical address width.
- `AHBW`, default 64: AHB data width; equals the cache word width on the bus side.
- `LINELEN`, default 512: cache line bits; `BEATSPERLINE = LINELEN/AHBW`, a power of two and at least 2.
- `LOGBWPL`, default `$clog2(LINELEN/AHBW)`: beat counter width.

Ports:
- `HCLK` in 1: the only clock, rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `CacheBusRW` in 2: bit 1 is line fetch, bit 0 is writeback. One-hot or zero; `2'b11` is illegal. Held until ack.
- `CacheBusAdr` in PA_BITS: line-aligned address, held until ack.
- `Flush` in 1: pipeline flush; cancels a request not yet accepted.
- `CacheReadDataWord` in AHBW: cache word at index `BeatCount` (writeback source).
- `CacheBusAck` out 1: one-cycle pulse when the burst completes.
- `BusCommitted` out 1: a burst is in flight and must not be interrupted.
- `SelBusBeat` out 1: the cache must index its word mux with `BeatCount`.
- `BeatCount` out LOGBWPL: index of the beat whose address phase is presented.
- `FetchBuffer` out LINELEN: assembled fetched line.
- `HADDR` out PA_BITS; `HTRANS` out 2; `HBURST` out 3; `HSIZE` out 3; `HWRITE` out 1; `HWDATA` out AHBW.
- `HREADY` in 1; `HRDATA` in AHBW.

## Operation
- **States.** IDLE, BURST, LAST.
- **IDLE**
  - If `CacheBusRW != 0` and `~Flush`: drive `HTRANS=NONSEQ` (2'b10), `HADDR=CacheBusAdr`, `BeatCount=0`.
  - On `HREADY`, the address phase is accepted: go to BURST and set the address counter to 1.
  - Without `HREADY`, stay in IDLE with all outputs held.
  - With `Flush` high, `HTRANS=IDLE` (2'b00) and there is no state change.
- **BURST**
  - Drive `HTRANS=SEQ` (2'b11) and `HADDR = {CacheBusAdr[PA_BITS-1:OFFSET], BeatCount, {log2(AHBW/8){0}}}`.
  - Each `HREADY` accepts the current address phase and completes the previous data phase.
  - When the beat with `BeatCount == BEATSPERLINE-1` is accepted, go to LAST.
  - `Flush` is ignored.
- **LAST**
  - Drive `HTRANS=IDLE`.
  - On `HREADY`, the final data phase completes: assert `CacheBusAck` for that cycle and go to IDLE.
- **Data-phase index.** A register loaded with `BeatCount` on each accepted address phase.
  - Reads: on each completed data phase, `HRDATA` is written into `FetchBuffer[idx*AHBW +: AHBW]`.
  - Writes: `HWDATA` is a register loaded from `CacheReadDataWord` when an address phase is accepted, so it is valid throughout that beat's data phase.
- **Static bus fields**
  - `HWRITE = CacheBusRW[0]`.
  - `HSIZE = log2(AHBW/8)`.
  - `HBURST`: INCR4=3'b011, INCR8=3'b101, INCR16=3'b111 for 4, 8, 16 beats; INCR=3'b001 otherwise.
- **Other outputs**
  - `SelBusBeat = 1` whenever the state is not IDLE, and also in IDLE while a request is presented.
  - `BusCommitted = 1` in BURST and LAST.
- **Beat counter.** `LOGBWPL` bits, clears to 0 on entering IDLE. It never wraps within a burst because LAST is entered on the all-ones beat.

## Timing
- **Reset.** Asserting `HRESETn` low sets, immediately and asynchronously:
  - state = IDLE;
  - counters = 0;
  - `FetchBuffer = 0`, `HWDATA = 0`;
  - `CacheBusAck = 0`, `BusCommitted = 0`, `HTRANS = IDLE`.

  Reset mid-burst abandons the burst and issues no ack.
- **Zero-wait latency.** Request in cycle 0 gives address phases in cycles 0..N-1 (N = BEATSPERLINE) and `CacheBusAck` in cycle N. N=8 means ack in cycle 8.
- **Wait states.** Each cycle with `HREADY=0` adds exactly one cycle; all outputs are held.
- **FetchBuffer visibility.** The fully assembled `FetchBuffer` is visible from the cycle after `CacheBusAck`.
- **Back-to-back requests.** A new request may be presented in the cycle after ack; it issues NONSEQ that cycle with no idle bubble.
- **Flush.** `Flush` and a request in the same cycle in IDLE: no bus activity and no ack.

## Test plan
- **Zero-wait fetch.** Fetch at 0x8000_0040, N=8, `HREADY=1`, `HRDATA` = beat index:
  - HADDR runs 0x40, 0x48, … 0x78;
  - HTRANS is NONSEQ then SEQ×7;
  - HBURST = 3'b101;
  - ack in cycle 8;
  - `FetchBuffer[63:0]=0` … `[511:448]=7`.
- **Wait states.** Same fetch with `HREADY` low for 2 cycles on beats 0 and 5: ack in cycle 12, same `FetchBuffer` contents, HADDR held steady during each stall.
- **Writeback.** Writeback at 0x8000_1000 with `CacheReadDataWord = 0xA0+BeatCount`:
  - HWRITE=1 throughout;
  - HWDATA is 0xA0 … 0xA7, each one cycle after its address phase;
  - ack in cycle 8.
- **Flush before acceptance.** `Flush=1` with a fetch request in IDLE: HTRANS=IDLE, no ack, `BusCommitted=0`. Dropping `Flush` with the request held starts the burst the next cycle.
- **Back-to-back.** Writeback then fetch on consecutive requests: the fetch's NONSEQ appears in the cycle after the writeback ack, and both bursts complete correctly.
- **Reset mid-burst.** Drop `HRESETn` at beat 3 of a fetch:
  - outputs clear immediately (HTRANS=IDLE, `BusCommitted=0`, `FetchBuffer=0`) with no ack;
  - a fetch issued after reset release completes normally.
